// File: rtl/wb_write_queue.sv
// Write-back request FIFO feeding the register file write port, with per-operand pending lookup.
// Optional macro WB_FWD_EN adds youngest-entry forwarding hit/data for rs1/rs2.
module wb_write_queue #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     wb_hold,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        write_reg_addr,
    output logic [DATA_W-1:0]        write_reg_data,
    input  logic [ADDR_W-1:0]        rs1_addr,
    input  logic [ADDR_W-1:0]        rs2_addr,
    output logic                     rs1_pending,
    output logic                     rs2_pending,
    output logic                     rs1_fwd_hit,
    output logic                     rs2_fwd_hit,
    output logic [DATA_W-1:0]        rs1_fwd_data,
    output logic [DATA_W-1:0]        rs2_fwd_data,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]         head_q, head_d, tail_q, tail_d, count;
    logic [ADDR_W-1:0]   addr_mem_q [DEPTH];
    logic [DATA_W-1:0]   data_mem_q [DEPTH];
    logic                regwrite_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                full, empty, push, pop;
    logic                q_hit1, q_hit2;

    // Extra pointer MSB distinguishes full from empty when indices coincide.
    assign count = tail_q - head_q;
    assign empty = (count == '0);
    assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    assign push  = in_valid && !full && (in_addr != '0);
    assign pop   = !empty && !wb_hold;

    assign head_d = pop  ? head_q + PTR_ONE : head_q;
    assign tail_d = push ? tail_q + PTR_ONE : tail_q;

    assign in_ready       = !full;
    assign occupancy      = count;
    assign RegWrite       = regwrite_q;
    assign write_reg_addr = waddr_q;
    assign write_reg_data = wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            regwrite_q <= pop;
            if (pop) begin
                waddr_q <= addr_mem_q[head_q[AW-1:0]];
                wdata_q <= data_mem_q[head_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[tail_q[AW-1:0]] <= in_addr;
            data_mem_q[tail_q[AW-1:0]] <= in_data;
        end
    end

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        logic [AW-1:0] offset;
        logic          live;
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        offset = '0;
        live   = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - head_q[AW-1:0];
            live   = ({1'b0, offset} < count);
            if (live && addr_mem_q[i] == rs1_addr) q_hit1 = 1'b1;
            if (live && addr_mem_q[i] == rs2_addr) q_hit2 = 1'b1;
        end
    end

    assign rs1_pending = (rs1_addr != '0) && (q_hit1 || (regwrite_q && waddr_q == rs1_addr));
    assign rs2_pending = (rs2_addr != '0) && (q_hit2 || (regwrite_q && waddr_q == rs2_addr));

`ifdef WB_FWD_EN
    // Walk oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        logic [AW-1:0] idx;
        logic          live;
        rs1_fwd_hit  = 1'b0;
        rs2_fwd_hit  = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
        idx          = '0;
        live         = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx  = head_q[AW-1:0] + AW'(k);
            live = ({1'b0, AW'(k)} < count);
            if (live && rs1_addr != '0 && addr_mem_q[idx] == rs1_addr) begin
                rs1_fwd_hit  = 1'b1;
                rs1_fwd_data = data_mem_q[idx];
            end
            if (live && rs2_addr != '0 && addr_mem_q[idx] == rs2_addr) begin
                rs2_fwd_hit  = 1'b1;
                rs2_fwd_data = data_mem_q[idx];
            end
        end
    end
`else
    assign rs1_fwd_hit  = 1'b0;
    assign rs2_fwd_hit  = 1'b0;
    assign rs1_fwd_data = '0;
    assign rs2_fwd_data = '0;
`endif

endmodule
